// File: rtl/mdio_slave.sv
// mdio_slave: Clause 22 MDIO management slave.
// Oversamples MDC/MDIO on the system clock, decodes read/write frames
// addressed to PHY_ADDRESS, and serves a 32 x 16 register file in which
// registers 2 and 3 are the read-only PHY identifier words.
module mdio_slave #(
  parameter logic [4:0]  PHY_ADDRESS  = 5'h01,
  parameter int          PREAMBLE_LEN = 32,
  parameter logic [15:0] PHY_ID1      = 16'h2000,
  parameter logic [15:0] PHY_ID2      = 16'hA231
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_data
);

  localparam int            CW      = $clog2(PREAMBLE_LEN + 1);
  localparam logic [CW-1:0] PRE_MAX = CW'(PREAMBLE_LEN);
  localparam logic [CW-1:0] PRE_ONE = CW'(1);

  typedef enum logic [3:0] {
    IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] pre_cnt, pre_cnt_nxt;
  logic [4:0]    bit_cnt, bit_cnt_nxt;
  logic          is_read, is_read_nxt;
  logic          phy_match, phy_match_nxt;
  logic [4:0]    addr_sr, addr_sr_nxt;
  logic [4:0]    reg_addr, reg_addr_nxt;
  logic [15:0]   data_sr, data_sr_nxt;
  logic          mdio_o_nxt, mdio_t_nxt;
  logic          wr_valid_nxt;
  logic [4:0]    wr_addr_nxt;
  logic [15:0]   wr_data_nxt;
  logic          rf_we;
  logic [15:0]   lookup_val;

  logic          mdc_s1, mdc_s2, mdc_d;
  logic          mdio_s1, mdio_s2;
  logic          mdc_rise;
  logic          bit_in;

  logic [15:0]   regs [32];

  // Registers 2 and 3 read back as the PHY identifier, everything else from storage.
  function automatic logic [15:0] reg_or_id(input logic [4:0] a, input logic [15:0] v);
    if (a == 5'd2) return PHY_ID1;
    if (a == 5'd3) return PHY_ID2;
    return v;
  endfunction

  // Two-flop synchronizers for the pad signals plus a delayed MDC for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdc_s1  <= 1'b0;
      mdc_s2  <= 1'b0;
      mdc_d   <= 1'b0;
      mdio_s1 <= 1'b0;
      mdio_s2 <= 1'b0;
    end else begin
      mdc_s1  <= mdc;
      mdc_s2  <= mdc_s1;
      mdc_d   <= mdc_s2;
      mdio_s1 <= mdio_i;
      mdio_s2 <= mdio_s1;
    end
  end

  assign mdc_rise = mdc_s2 & ~mdc_d;
  assign bit_in   = mdio_s2;

  // Read data for the register address being completed on this MDC edge.
  always_comb begin
    lookup_val = reg_or_id({addr_sr[3:0], bit_in}, regs[{addr_sr[3:0], bit_in}]);
  end

  // Frame state register and registered pad/write outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      is_read   <= 1'b0;
      phy_match <= 1'b0;
      addr_sr   <= '0;
      reg_addr  <= '0;
      data_sr   <= '0;
      mdio_o    <= 1'b1;
      mdio_t    <= 1'b1;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_nxt;
      pre_cnt   <= pre_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      is_read   <= is_read_nxt;
      phy_match <= phy_match_nxt;
      addr_sr   <= addr_sr_nxt;
      reg_addr  <= reg_addr_nxt;
      data_sr   <= data_sr_nxt;
      mdio_o    <= mdio_o_nxt;
      mdio_t    <= mdio_t_nxt;
      wr_valid  <= wr_valid_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
    end
  end

  // Frame decoder: advances one bit per detected MDC rising edge.
  always_comb begin
    state_nxt     = state;
    pre_cnt_nxt   = pre_cnt;
    bit_cnt_nxt   = bit_cnt;
    is_read_nxt   = is_read;
    phy_match_nxt = phy_match;
    addr_sr_nxt   = addr_sr;
    reg_addr_nxt  = reg_addr;
    data_sr_nxt   = data_sr;
    mdio_o_nxt    = mdio_o;
    mdio_t_nxt    = mdio_t;
    wr_valid_nxt  = 1'b0;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    rf_we         = 1'b0;

    if (mdc_rise) begin
      case (state)
        IDLE: begin
          if (bit_in) begin
            if (pre_cnt != PRE_MAX) pre_cnt_nxt = pre_cnt + PRE_ONE;
          end else begin
            pre_cnt_nxt = '0;
            if (pre_cnt == PRE_MAX) state_nxt = ST;
          end
        end
        ST: begin
          bit_cnt_nxt = '0;
          state_nxt   = bit_in ? OP : IDLE;
        end
        OP: begin
          if (bit_cnt == 5'd0) begin
            is_read_nxt = bit_in;
            bit_cnt_nxt = 5'd1;
          end else begin
            bit_cnt_nxt = '0;
            state_nxt   = (is_read != bit_in) ? PHYAD : IDLE;
          end
        end
        PHYAD: begin
          addr_sr_nxt = {addr_sr[3:0], bit_in};
          if (bit_cnt == 5'd4) begin
            phy_match_nxt = (addr_sr_nxt == PHY_ADDRESS);
            bit_cnt_nxt   = '0;
            state_nxt     = REGAD;
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end
        REGAD: begin
          addr_sr_nxt = {addr_sr[3:0], bit_in};
          if (bit_cnt == 5'd4) begin
            reg_addr_nxt = addr_sr_nxt;
            bit_cnt_nxt  = '0;
            if (phy_match) begin
              data_sr_nxt = is_read ? lookup_val : 16'h0000;
              state_nxt   = TA;
            end else begin
              state_nxt = SKIP;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end
        TA: begin
          if (bit_cnt == 5'd0) begin
            bit_cnt_nxt = 5'd1;
            if (is_read) begin
              mdio_t_nxt = 1'b0;
              mdio_o_nxt = 1'b0;
            end
          end else begin
            bit_cnt_nxt = '0;
            if (is_read) begin
              mdio_o_nxt  = data_sr[15];
              data_sr_nxt = {data_sr[14:0], 1'b0};
              state_nxt   = RDATA;
            end else begin
              state_nxt = WDATA;
            end
          end
        end
        RDATA: begin
          if (bit_cnt == 5'd15) begin
            mdio_t_nxt  = 1'b1;
            mdio_o_nxt  = 1'b1;
            bit_cnt_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            mdio_o_nxt  = data_sr[15];
            data_sr_nxt = {data_sr[14:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end
        WDATA: begin
          data_sr_nxt = {data_sr[14:0], bit_in};
          if (bit_cnt == 5'd15) begin
            bit_cnt_nxt = '0;
            state_nxt   = IDLE;
            if (reg_addr != 5'd2 && reg_addr != 5'd3) begin
              rf_we        = 1'b1;
              wr_valid_nxt = 1'b1;
              wr_addr_nxt  = reg_addr;
              wr_data_nxt  = data_sr_nxt;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end
        SKIP: begin
          if (bit_cnt == 5'd17) begin
            bit_cnt_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end
        default: begin
          bit_cnt_nxt = '0;
          pre_cnt_nxt = '0;
          mdio_t_nxt  = 1'b1;
          mdio_o_nxt  = 1'b1;
          state_nxt   = IDLE;
        end
      endcase
    end
  end

  // Register file storage, written on the last data bit of an accepted write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we) begin
      regs[reg_addr] <= wr_data_nxt;
    end
  end

  // Registered local read port; a same-cycle MDIO write shows up one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= reg_or_id(rd_addr, regs[rd_addr]);
    end
  end

endmodule

// File: tb/tb_mdio_slave.sv
// tb_mdio_slave: directed MDIO frames with a scoreboard; expected writes and
// read words are queued by the stimulus and consumed by a clock-driven monitor.
module tb_mdio_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_t;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic [4:0]  rd_addr;
  logic [15:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [20:0] wr_exp [$];
  logic [15:0] rd_exp [$];
  int          wr_count = 0;
  int          drive_count = 0;

  logic        prev_t = 1'b1;
  logic        prev_mdc = 1'b0;
  logic        mon_active = 1'b0;
  int          mon_rises = 0;
  int          release_wait = 0;
  logic [15:0] mon_word = '0;
  logic [20:0] wr_pop;
  logic        old_chk_en = 1'b0;
  logic [15:0] old_chk_val = '0;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  always #5 clk = ~clk;

  mdio_slave #(
    .PHY_ADDRESS (5'h01),
    .PREAMBLE_LEN(32),
    .PHY_ID1     (16'h2000),
    .PHY_ID2     (16'hA231)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .mdc     (mdc),
    .mdio_i  (mdio_i),
    .mdio_o  (mdio_o),
    .mdio_t  (mdio_t),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mdc_bit(input logic b);
    mdio_i = b;
    mdc = 1'b0;
    wait_clk(8);
    mdc = 1'b1;
    wait_clk(8);
    mdc = 1'b0;
  endtask

  // Drives one frame; stop_bit >= 0 truncates the frame after that frame bit.
  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] regad,
                               input logic [15:0] data, input int pre_len, input int stop_bit);
    logic [31:0] frame;
    logic [1:0]  ta;
    ta = (op == OP_WR) ? 2'b10 : 2'b11;
    frame = {2'b01, op, phy, regad, ta, (op == OP_WR) ? data : 16'hFFFF};
    for (int i = 0; i < pre_len; i++) mdc_bit(1'b1);
    for (int i = 0; i < 32; i++) begin
      if (stop_bit < 0 || i <= stop_bit) mdc_bit(frame[31-i]);
    end
    mdio_i = 1'b1;
  endtask

  task automatic check_local(input string name, input logic [4:0] addr, input logic [15:0] expected);
    rd_addr = addr;
    wait_clk(2);
    checkOutput(name, 32'(rd_data), 32'(expected));
  endtask

  task automatic check_drained(input string name);
    wait_clk(12);
    checkOutput({name, "_wr_pending"}, 32'(wr_exp.size()), 32'd0);
    checkOutput({name, "_rd_pending"}, 32'(rd_exp.size()), 32'd0);
  endtask

  // Monitor: follows bus drive and write pulses, popping expectations from the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      mon_active   = 1'b0;
      release_wait = 0;
      prev_t       = 1'b1;
    end else begin
      if (prev_t && !mdio_t) begin
        drive_count++;
        checkOutput("drive_expected", 32'(rd_exp.size() != 0), 32'd1);
        checkOutput("ta_level", 32'(mdio_o), 32'd0);
        mon_active = 1'b1;
        mon_rises  = 0;
        mon_word   = '0;
      end
      if (mon_active && mdc && !prev_mdc) begin
        mon_rises++;
        checkOutput("bus_driven", 32'(mdio_t), 32'd0);
        if (mon_rises == 1) begin
          checkOutput("ta_bit2", 32'(mdio_o), 32'd0);
        end else begin
          mon_word = {mon_word[14:0], mdio_o};
          if (mon_rises == 17) begin
            mon_active   = 1'b0;
            release_wait = 6;
            if (rd_exp.size() != 0) checkOutput("rd_word", 32'(mon_word), 32'(rd_exp.pop_front()));
          end
        end
      end else if (release_wait > 0) begin
        release_wait--;
        if (release_wait == 0) checkOutput("bus_released", 32'(mdio_t), 32'd1);
      end
      if (wr_valid) begin
        wr_count++;
        if (wr_exp.size() == 0) begin
          checkOutput("unexpected_write", 32'd1, 32'd0);
        end else begin
          wr_pop = wr_exp.pop_front();
          checkOutput("wr_addr", 32'(wr_addr), 32'(wr_pop[20:16]));
          checkOutput("wr_data", 32'(wr_data), 32'(wr_pop[15:0]));
        end
        if (old_chk_en) begin
          checkOutput("rd_old_value", 32'(rd_data), 32'(old_chk_val));
          old_chk_en = 1'b0;
        end
      end
      prev_t = mdio_t;
    end
    prev_mdc = mdc;
  end

  initial begin
    int wr_before;
    int drv_before;

    reset   = 1'b0;
    mdc     = 1'b0;
    mdio_i  = 1'b1;
    rd_addr = 5'h10;
    wait_clk(3);
    checkOutput("reset_mdio_t", 32'(mdio_t), 32'd1);
    checkOutput("reset_mdio_o", 32'(mdio_o), 32'd1);
    checkOutput("reset_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("reset_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("reset_wr_data", 32'(wr_data), 32'd0);
    checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b1;
    wait_clk(4);
    check_local("rf_init_0x10", 5'h10, 16'h0000);

    // Basic write then local read-back.
    wr_exp.push_back({5'h10, 16'hBEEF});
    applyStimulus(OP_WR, 5'h01, 5'h10, 16'hBEEF, 32, -1);
    check_drained("wr_beef");
    checkOutput("wr_beef_count", 32'(wr_count), 32'd1);
    check_local("local_0x10", 5'h10, 16'hBEEF);

    // MDIO read of the same register.
    drv_before = drive_count;
    rd_exp.push_back(16'hBEEF);
    applyStimulus(OP_RD, 5'h01, 5'h10, 16'h0000, 32, -1);
    check_drained("rd_beef");
    checkOutput("rd_beef_drives", 32'(drive_count - drv_before), 32'd1);

    // PHY identifier registers and a discarded write to one of them.
    rd_exp.push_back(16'h2000);
    applyStimulus(OP_RD, 5'h01, 5'h02, 16'h0000, 32, -1);
    rd_exp.push_back(16'hA231);
    applyStimulus(OP_RD, 5'h01, 5'h03, 16'h0000, 32, -1);
    check_drained("rd_ids");
    check_local("local_id1", 5'h02, 16'h2000);
    check_local("local_id2", 5'h03, 16'hA231);
    wr_before = wr_count;
    applyStimulus(OP_WR, 5'h01, 5'h02, 16'h1234, 32, -1);
    check_drained("wr_id");
    checkOutput("wr_id_discarded", 32'(wr_count - wr_before), 32'd0);
    rd_exp.push_back(16'h2000);
    applyStimulus(OP_RD, 5'h01, 5'h02, 16'h0000, 32, -1);
    check_drained("rd_id_again");

    // Local read held on the address being written sees the old value first.
    rd_addr = 5'h05;
    wait_clk(2);
    old_chk_en  = 1'b1;
    old_chk_val = 16'h0000;
    wr_exp.push_back({5'h05, 16'h0042});
    applyStimulus(OP_WR, 5'h01, 5'h05, 16'h0042, 32, -1);
    check_drained("wr_0x05");
    checkOutput("old_value_checked", 32'(old_chk_en), 32'd0);
    checkOutput("rd_new_value", 32'(rd_data), 32'h0042);

    // Foreign PHY address and a short preamble are ignored.
    wr_before  = wr_count;
    drv_before = drive_count;
    applyStimulus(OP_WR, 5'h07, 5'h10, 16'h1111, 32, -1);
    applyStimulus(OP_RD, 5'h07, 5'h10, 16'h0000, 32, -1);
    applyStimulus(OP_WR, 5'h01, 5'h10, 16'h5555, 31, -1);
    check_drained("ignored");
    checkOutput("ignored_writes", 32'(wr_count - wr_before), 32'd0);
    checkOutput("ignored_drives", 32'(drive_count - drv_before), 32'd0);
    check_local("local_0x10_kept", 5'h10, 16'hBEEF);
    wr_exp.push_back({5'h11, 16'hA5A5});
    applyStimulus(OP_WR, 5'h01, 5'h11, 16'hA5A5, 32, -1);
    rd_exp.push_back(16'hA5A5);
    applyStimulus(OP_RD, 5'h01, 5'h11, 16'h0000, 32, -1);
    check_drained("recover");

    // Invalid opcode produces no response.
    wr_before  = wr_count;
    drv_before = drive_count;
    applyStimulus(OP_BAD, 5'h01, 5'h10, 16'h0000, 32, -1);
    check_drained("op11");
    checkOutput("op11_writes", 32'(wr_count - wr_before), 32'd0);
    checkOutput("op11_drives", 32'(drive_count - drv_before), 32'd0);

    // Reset while D5 of a read is on the bus.
    rd_exp.push_back(16'hBEEF);
    applyStimulus(OP_RD, 5'h01, 5'h10, 16'h0000, 32, 25);
    checkOutput("abort_driving", 32'(mdio_t), 32'd0);
    checkOutput("abort_d5", 32'(mdio_o), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort_release_t", 32'(mdio_t), 32'd1);
    checkOutput("abort_release_o", 32'(mdio_o), 32'd1);
    wait_clk(4);
    rd_exp.delete();
    reset = 1'b1;
    wait_clk(4);
    check_local("post_reset_0x10", 5'h10, 16'h0000);
    check_local("post_reset_0x11", 5'h11, 16'h0000);
    check_local("post_reset_0x05", 5'h05, 16'h0000);
    rd_exp.push_back(16'h0000);
    applyStimulus(OP_RD, 5'h01, 5'h10, 16'h0000, 32, -1);
    check_drained("post_reset_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
